// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling FSM and a small
// byte FIFO read through a valid/ack handshake, with sticky error flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic               com_RxD,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ack,
  output logic [FIFO_AW:0]   rx_count,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clr,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic             sync1_q;
  logic             rxs_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_req;
  logic             ferr_set;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             ovr_set;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= com_RxD;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = rx_ack && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);
  assign ovr_set    = push_req && fifo_full && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    overrun_d   = ovr_set | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
    end
  end

  assign rx_data   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign rx_valid  = !fifo_empty;
  assign rx_count  = wr_ptr_q - rd_ptr_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
